// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (DrawX/DrawY, blank, hs/vs, pix_ce, frame_start); VGA_TIMING_TEST_PATTERN_EN adds colour bars.
// Latency: every output is registered one vga_clk behind the raster counters and advances once per CLK_DIV cycles.
// Backpressure: none, free-running source; consumers qualify with pix_ce and gate colour with blank.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 1
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       sync,
    output logic       pix_ce,
    output logic       frame_start
`ifdef VGA_TIMING_TEST_PATTERN_EN
    ,
    output logic [3:0] tp_red,
    output logic [3:0] tp_green,
    output logic [3:0] tp_blue
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Refuse to elaborate geometries the 10-bit counters or 2-bit divider cannot represent
    if (H_TOTAL > 1024) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL=%0d exceeds 1024", H_TOTAL);
    end
    if (V_TOTAL > 1024) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL=%0d exceeds 1024", V_TOTAL);
    end
    if ((CLK_DIV < 1) || (CLK_DIV > 4)) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV=%0d outside 1..4", CLK_DIV);
    end

    // Region boundaries are held at 11 bits so an end point equal to 1024 still compares correctly
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [1:0]  DIV_LAST   = 2'(CLK_DIV - 1);

    logic [1:0]  div_cnt;
    logic        tick;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [10:0] h_ext;
    logic [10:0] v_ext;
    logic        blank_nxt;
    logic        hs_nxt;
    logic        vs_nxt;
    logic        fs_nxt;

    // Composite sync is not used by this display path
    assign sync = 1'b0;

    // One tick per pixel period; with CLK_DIV=1 the divider stays at 0 and tick is constant high
    assign tick = (div_cnt == DIV_LAST);

    // Pixel-rate divider
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            div_cnt <= 2'd0;
        end else if (tick) begin
            div_cnt <= 2'd0;
        end else begin
            div_cnt <= div_cnt + 2'd1;
        end
    end

    // Raster counters: column advances per tick, line advances on the column wrap
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else if (tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= 10'd0;
                if (v_cnt == V_LAST) begin
                    v_cnt <= 10'd0;
                end else begin
                    v_cnt <= v_cnt + 10'd1;
                end
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Decode the pixel the counters currently point at
    always_comb begin
        h_ext     = {1'b0, h_cnt};
        v_ext     = {1'b0, v_cnt};
        blank_nxt = (h_ext < H_VIS_END) && (v_ext < V_VIS_END);
        hs_nxt    = !((h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END));
        vs_nxt    = !((v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END));
        fs_nxt    = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end

    // Output stage: capture the decoded pixel on tick edges so all outputs describe the same pixel
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            DrawX       <= 10'd0;
            DrawY       <= 10'd0;
            blank       <= 1'b0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            pix_ce      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_ce <= tick;
            if (tick) begin
                DrawX       <= h_cnt;
                DrawY       <= v_cnt;
                blank       <= blank_nxt;
                hs          <= hs_nxt;
                vs          <= vs_nxt;
                frame_start <= fs_nxt;
            end
        end
    end

`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [12:0] h_x8;
    logic [2:0]  bar_nxt;

    // Bar index = floor(h_cnt*8 / H_VISIBLE), found by counting the boundaries already passed
    always_comb begin
        h_x8    = {h_cnt, 3'b000};
        bar_nxt = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h_x8 >= 13'(k * H_VISIBLE)) begin
                bar_nxt = 3'(k);
            end
        end
    end

    // Colour bars registered alongside DrawX; dark outside active video
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            tp_red   <= 4'h0;
            tp_green <= 4'h0;
            tp_blue  <= 4'h0;
        end else if (tick) begin
            if (blank_nxt) begin
                tp_red   <= {4{bar_nxt[2]}};
                tp_green <= {4{bar_nxt[1]}};
                tp_blue  <= {4{bar_nxt[0]}};
            end else begin
                tp_red   <= 4'h0;
                tp_green <= 4'h0;
                tp_blue  <= 4'h0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks two instances, default geometry at CLK_DIV=1 and a short-frame CLK_DIV=2 build.
// Latency: expected outputs come from a closed-form pixel model keyed on edges since reset release.
// Backpressure: not applicable; the DUT is a free-running source.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        blank;
        logic        hs;
        logic        vs;
        logic        sync;
        logic        pce;
        logic        fs;
        logic [11:0] rgb;
    } obs_t;

    typedef struct {
        logic rst_n;
        int   cycles;
        obs_t exp;
    } vec_t;

    logic vga_clk = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    bit   b_done  = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 vga_clk = ~vga_clk;

    logic [9:0]  x_a, y_a, x_b, y_b;
    logic        blank_a, hs_a, vs_a, sync_a, pce_a, fs_a;
    logic        blank_b, hs_b, vs_b, sync_b, pce_b, fs_b;
    logic [11:0] rgb_a, rgb_b;
    obs_t        obs_a, obs_b;

`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [3:0] tr_a, tg_a, tb_a, tr_b, tg_b, tb_b;
    assign rgb_a = {tr_a, tg_a, tb_a};
    assign rgb_b = {tr_b, tg_b, tb_b};
`else
    assign rgb_a = 12'h000;
    assign rgb_b = 12'h000;
`endif

    assign obs_a = {x_a, y_a, blank_a, hs_a, vs_a, sync_a, pce_a, fs_a, rgb_a};
    assign obs_b = {x_b, y_b, blank_b, hs_b, vs_b, sync_b, pce_b, fs_b, rgb_b};

    vga_timing_gen u_dut_a (
        .vga_clk     (vga_clk),
        .reset_n     (rst_a_n),
        .DrawX       (x_a),
        .DrawY       (y_a),
        .blank       (blank_a),
        .hs          (hs_a),
        .vs          (vs_a),
        .sync        (sync_a),
        .pix_ce      (pce_a),
        .frame_start (fs_a)
`ifdef VGA_TIMING_TEST_PATTERN_EN
        ,
        .tp_red      (tr_a),
        .tp_green    (tg_a),
        .tp_blue     (tb_a)
`endif
    );

    vga_timing_gen #(
        .V_VISIBLE (8),
        .V_FP      (1),
        .V_SYNC    (2),
        .V_BP      (2),
        .CLK_DIV   (2)
    ) u_dut_b (
        .vga_clk     (vga_clk),
        .reset_n     (rst_b_n),
        .DrawX       (x_b),
        .DrawY       (y_b),
        .blank       (blank_b),
        .hs          (hs_b),
        .vs          (vs_b),
        .sync        (sync_b),
        .pix_ce      (pce_b),
        .frame_start (fs_b)
`ifdef VGA_TIMING_TEST_PATTERN_EN
        ,
        .tp_red      (tr_b),
        .tp_green    (tg_b),
        .tp_blue     (tb_b)
`endif
    );

    function automatic logic [11:0] tpx(input logic [11:0] v);
`ifdef VGA_TIMING_TEST_PATTERN_EN
        return v;
`else
        return 12'h000 & v;
`endif
    endfunction

    function automatic obs_t mk(input int x, input int y, input logic b, input logic h,
                                input logic v, input logic p, input logic f, input logic [11:0] rgb);
        obs_t o;
        o.x = 10'(x);
        o.y = 10'(y);
        o.blank = b;
        o.hs = h;
        o.vs = v;
        o.sync = 1'b0;
        o.pce = p;
        o.fs = f;
        o.rgb = tpx(rgb);
        return o;
    endfunction

    // Closed-form expectation: k = vga_clk edges since the last edge that sampled reset low
    function automatic obs_t model(input int k, input int cd, input int hv, input int hf, input int hsw,
                                   input int hb, input int vv, input int vf, input int vsw, input int vb);
        obs_t o;
        int ht, vt, p, x, y, bar;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        if (k >= cd) begin
            ht = hv + hf + hsw + hb;
            vt = vv + vf + vsw + vb;
            p = k / cd - 1;
            x = p % ht;
            y = (p / ht) % vt;
            o.x = 10'(x);
            o.y = 10'(y);
            o.pce = ((k % cd) == 0);
            o.blank = (x < hv) && (y < vv);
            o.hs = !((x >= hv + hf) && (x < hv + hf + hsw));
            o.vs = !((y >= vv + vf) && (y < vv + vf + vsw));
            o.fs = (x == 0) && (y == 0);
`ifdef VGA_TIMING_TEST_PATTERN_EN
            if (o.blank) begin
                bar = (x * 8) / hv;
                o.rgb = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
            end
`endif
        end
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t got, input obs_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got x=%0d y=%0d blank=%b hs=%b vs=%b sync=%b pce=%b fs=%b rgb=%h ; expected x=%0d y=%0d blank=%b hs=%b vs=%b sync=%b pce=%b fs=%b rgb=%h",
                     name, $time, got.x, got.y, got.blank, got.hs, got.vs, got.sync, got.pce, got.fs, got.rgb,
                     exp.x, exp.y, exp.blank, exp.hs, exp.vs, exp.sync, exp.pce, exp.fs, exp.rgb);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Scoreboard: expectation pushed as each edge applies reset_n, popped at the following negedge
    obs_t q_a[$];
    obs_t q_b[$];
    int   k_a = 0;
    int   k_b = 0;

    always @(posedge vga_clk) begin
        q_a.push_back(model(rst_a_n ? k_a + 1 : 0, 1, 640, 16, 96, 48, 480, 10, 2, 33));
        q_b.push_back(model(rst_b_n ? k_b + 1 : 0, 2, 640, 16, 96, 48, 8, 1, 2, 2));
        k_a <= rst_a_n ? k_a + 1 : 0;
        k_b <= rst_b_n ? k_b + 1 : 0;
    end

    always @(negedge vga_clk) begin
        if (q_a.size() != 0) check_obs("sb_a", obs_a, q_a.pop_front());
        if (q_b.size() != 0) check_obs("sb_b", obs_b, q_b.pop_front());
    end

    // Pulse-width and frame-period monitors on the CLK_DIV=2 instance; a reset discards a pulse in flight
    logic hs_prev = 1'b1, vs_prev = 1'b1, fs_prev = 1'b0;
    bit   hs_arm = 1'b0, vs_arm = 1'b0, fs_arm = 1'b0;
    int   hs_len = 0, vs_ticks = 0, fs_run = 0, fs_last = 0, cyc = 0;

    always @(negedge vga_clk) begin
        cyc <= cyc + 1;
        hs_prev <= hs_b;
        vs_prev <= vs_b;
        fs_prev <= fs_b;
        if (!rst_b_n) begin
            hs_arm <= 1'b0;
            vs_arm <= 1'b0;
            fs_arm <= 1'b0;
            fs_run <= 0;
        end else begin
            if (hs_prev && !hs_b) begin
                hs_arm <= 1'b1;
                hs_len <= 1;
            end else if (!hs_b) begin
                hs_len <= hs_len + 1;
            end else if (!hs_prev && hs_arm) begin
                chk_int("hs_low_cycles", hs_len, 192);
                hs_arm <= 1'b0;
            end

            if (vs_prev && !vs_b) begin
                vs_arm <= 1'b1;
                vs_ticks <= int'(pce_b);
            end else if (!vs_b) begin
                vs_ticks <= vs_ticks + int'(pce_b);
            end else if (!vs_prev && vs_arm) begin
                chk_int("vs_low_ticks", vs_ticks, 1600);
                vs_arm <= 1'b0;
            end

            if (!fs_prev && fs_b) begin
                if (fs_arm) chk_int("frame_period_cycles", cyc - fs_last, 20800);
                fs_arm <= 1'b1;
                fs_last <= cyc;
                fs_run <= 1;
            end else if (fs_b) begin
                fs_run <= fs_run + 1;
            end else if (fs_prev) begin
                chk_int("frame_start_cycles", fs_run, 2);
            end
        end
    end

    // Table-driven walk across the first lines of the default-geometry instance
    initial begin : seq_a
        vec_t tbl[14];
        tbl[0]  = '{rst_n: 1'b0, cycles: 5,   exp: mk(0,   0, 0, 1, 1, 0, 0, 12'h000)};
        tbl[1]  = '{rst_n: 1'b1, cycles: 1,   exp: mk(0,   0, 1, 1, 1, 1, 1, 12'h000)};
        tbl[2]  = '{rst_n: 1'b1, cycles: 1,   exp: mk(1,   0, 1, 1, 1, 1, 0, 12'h000)};
        tbl[3]  = '{rst_n: 1'b1, cycles: 79,  exp: mk(80,  0, 1, 1, 1, 1, 0, 12'h00F)};
        tbl[4]  = '{rst_n: 1'b1, cycles: 559, exp: mk(639, 0, 1, 1, 1, 1, 0, 12'hFFF)};
        tbl[5]  = '{rst_n: 1'b1, cycles: 1,   exp: mk(640, 0, 0, 1, 1, 1, 0, 12'h000)};
        tbl[6]  = '{rst_n: 1'b1, cycles: 15,  exp: mk(655, 0, 0, 1, 1, 1, 0, 12'h000)};
        tbl[7]  = '{rst_n: 1'b1, cycles: 1,   exp: mk(656, 0, 0, 0, 1, 1, 0, 12'h000)};
        tbl[8]  = '{rst_n: 1'b1, cycles: 44,  exp: mk(700, 0, 0, 0, 1, 1, 0, 12'h000)};
        tbl[9]  = '{rst_n: 1'b1, cycles: 51,  exp: mk(751, 0, 0, 0, 1, 1, 0, 12'h000)};
        tbl[10] = '{rst_n: 1'b1, cycles: 1,   exp: mk(752, 0, 0, 1, 1, 1, 0, 12'h000)};
        tbl[11] = '{rst_n: 1'b1, cycles: 47,  exp: mk(799, 0, 0, 1, 1, 1, 0, 12'h000)};
        tbl[12] = '{rst_n: 1'b1, cycles: 1,   exp: mk(0,   1, 1, 1, 1, 1, 0, 12'h000)};
        tbl[13] = '{rst_n: 1'b1, cycles: 639, exp: mk(639, 1, 1, 1, 1, 1, 0, 12'hFFF)};
        for (int i = 0; i < 14; i++) begin
            rst_a_n = tbl[i].rst_n;
            repeat (tbl[i].cycles) @(posedge vga_clk);
            @(negedge vga_clk);
            check_obs($sformatf("tbl_a[%0d]", i), obs_a, tbl[i].exp);
        end
        wait (b_done);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hand sequence on the CLK_DIV=2 instance: pixel hold, then a reset in the middle of an hs pulse
    initial begin : seq_b
        bit found;
        found = 1'b0;
        repeat (5) @(posedge vga_clk);
        #1 rst_b_n = 1'b1;
        @(posedge vga_clk); #1;
        check_obs("b_release_hold", obs_b, mk(0, 0, 0, 1, 1, 0, 0, 12'h000));
        @(posedge vga_clk); #1;
        check_obs("b_first_pixel", obs_b, mk(0, 0, 1, 1, 1, 1, 1, 12'h000));
        @(posedge vga_clk); #1;
        check_obs("b_first_pixel_held", obs_b, mk(0, 0, 1, 1, 1, 0, 1, 12'h000));
        @(posedge vga_clk); #1;
        check_obs("b_second_pixel", obs_b, mk(1, 0, 1, 1, 1, 1, 0, 12'h000));

        for (int i = 0; i < 30000 && !found; i++) begin
            @(negedge vga_clk);
            if (x_b == 10'd700 && y_b == 10'd5) found = 1'b1;
        end
        chk_int("mid_point_reached", int'(found), 1);
        chk_int("mid_point_hs", int'(hs_b), 0);

        @(posedge vga_clk); #1 rst_b_n = 1'b0;
        @(posedge vga_clk); #1;
        check_obs("mid_reset_edge", obs_b, mk(0, 0, 0, 1, 1, 0, 0, 12'h000));
        rst_b_n = 1'b1;
        @(posedge vga_clk); #1;
        check_obs("mid_reset_release", obs_b, mk(0, 0, 0, 1, 1, 0, 0, 12'h000));
        @(posedge vga_clk); #1;
        check_obs("mid_reset_first_pixel", obs_b, mk(0, 0, 1, 1, 1, 1, 1, 12'h000));

        repeat (2 * 20800 + 50) @(posedge vga_clk);
        b_done = 1'b1;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates raster timing for the VGA display path: pixel coordinates, sync pulses and the active-video qualifier.
- It is the driving end of the DrawX/DrawY/blank interface that sprite and background renderers consume; each renderer fetches ROM or palette data from these coordinates and gates its colour output with blank.
- Its hs/vs outputs go straight to the VGA connector.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, horizontal sync width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width, in lines
- V_BP, 33, vertical back porch, in lines
- CLK_DIV, 1, vga_clk cycles per pixel; legal range 1..4

Ports:
- vga_clk  in  1  pixel/system clock
- reset_n  in  1  synchronous, active-low reset
- DrawX  out  10  current pixel column
- DrawY  out  10  current pixel line
- blank  out  1  1 = active video (renderers drive colour only when high); 0 = porch or sync
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- sync  out  1  composite sync; tied to 0
- pix_ce  out  1  one-cycle pulse on each vga_clk cycle where the outputs advance
- frame_start  out  1  high for the single pixel period where DrawX=0 and DrawY=0

Behaviour:
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (default 525).
- Both totals must be <=1024. Elaboration fails via a generate-time check otherwise, and also if CLK_DIV is outside 1..4.
- Divider:
  - div_cnt counts 0..CLK_DIV-1.
  - tick is asserted when div_cnt == CLK_DIV-1.
  - With CLK_DIV=1, tick is asserted every cycle.
- Counters:
  - h_cnt increments on tick and wraps H_TOTAL-1 -> 0.
  - On that wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
  - Counters are unsigned 10-bit; no other wrap points exist.
- Output stage: all outputs are registered from (h_cnt, v_cnt) and update only on the vga_clk edge where tick was high, so they lag the counters by one vga_clk cycle.
  - DrawX = h_cnt, DrawY = v_cnt.
  - blank = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
  - hs = 0 when H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC; otherwise 1.
  - vs = 0 when V_VISIBLE+V_FP <= v_cnt < V_VISIBLE+V_FP+V_SYNC; otherwise 1. vs changes only together with the DrawX 0 boundary.
  - frame_start = (h_cnt == 0 && v_cnt == 0). It holds for the whole pixel period (CLK_DIV cycles).
  - pix_ce is registered tick: high for exactly one vga_clk in each pixel period.
- All outputs are mutually aligned: every output describes the same pixel in the same cycle.
- Reset (reset_n=0 at a vga_clk edge):
  - div_cnt=0, h_cnt=0, v_cnt=0.
  - DrawX=0, DrawY=0, blank=0, hs=1, vs=1, pix_ce=0, frame_start=0.
- First pixel after reset release:
  - The first tick edge after reset release presents pixel (0,0).
  - On that edge blank=1, frame_start=1, pix_ce=1.
  - That edge occurs CLK_DIV edges after release.
- Mid-frame reset: takes effect on the same edge; the raster restarts at (0,0) with no partial sync pulse carried over.
- Sync width: hs is low for exactly H_SYNC×CLK_DIV vga_clk cycles per line.

Optional Feature:
- Macro: VGA_TIMING_TEST_PATTERN_EN.
- When defined, adds outputs tp_red, tp_green, tp_blue (out, 4 bits each), registered and aligned with DrawX.
  - Bar index b = (DrawX × 8) / H_VISIBLE, in the range 0..7.
  - tp_red = {4{b[2]}}, tp_green = {4{b[1]}}, tp_blue = {4{b[0]}}.
  - All three are 0 whenever blank=0 and during reset.
- When not defined, these ports and their logic do not exist.

Test Plan:
- Reset: hold reset_n=0 for 5 cycles -> DrawX=0, DrawY=0, blank=0, hs=1, vs=1, pix_ce=0, frame_start=0. First pix_ce after release shows (0,0) with blank=1 and frame_start=1.
- Horizontal timing, defaults: hs low exactly for DrawX 656..751 (96 ticks); blank falls at DrawX=640; line period 800 ticks; DrawY increments when DrawX wraps 799->0.
- Vertical timing: vs low exactly for DrawY 490..491, i.e. 1600 ticks. Frame period is 420000 ticks with exactly one frame_start per frame. blank stays 0 for all of DrawY 480..524.
- CLK_DIV=2: pix_ce high every 2nd vga_clk. DrawX holds each value 2 cycles. Line = 1600 vga_clk cycles. hs low for 192 cycles.
- Mid-frame reset: assert reset_n=0 for 1 cycle at DrawX=700, DrawY=300 (hs=0) -> the next edge shows hs=1, DrawX=0, DrawY=0, blank=0, and the raster restarts cleanly.
- VGA_TIMING_TEST_PATTERN_EN defined: DrawX=0 -> rgb 0/0/0; DrawX=80 -> 0/0/F; DrawX=639 -> F/F/F; DrawX=700 -> 0/0/0.
